// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE operand bundle and registered EXE results
// The ov member and its modport entries exist only when EXE_OVF_EN is defined.
interface exe_stage_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       ealuc;
  logic             ealuimm;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] eimm;
  logic             eshift;
  logic [WIDTH-1:0] ealu;
  logic             z;
`ifdef EXE_OVF_EN
  logic             ov;
`endif

  // Master is the ID/EXE side that supplies operands and consumes the results.
  modport master (
    output ealuc, ealuimm, ea, eb, eimm, eshift,
`ifdef EXE_OVF_EN
    input  ov,
`endif
    input  ealu, z
  );

  modport slave (
    input  ealuc, ealuimm, ea, eb, eimm, eshift,
`ifdef EXE_OVF_EN
    output ov,
`endif
    output ealu, z
  );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: operand select, 8-op ALU, registered result/zero flag
// Define EXE_OVF_EN to add the registered signed-overflow flag (bus.ov).
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  exe_stage_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] alua;
  logic [WIDTH-1:0] alub;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] r;

  // The shift amount field of the instruction rides in the immediate bits 10:6.
  always_comb begin
    sa    = {{(WIDTH-5){1'b0}}, bus.eimm[10:6]};
    alua  = bus.eshift  ? sa       : bus.ea;
    alub  = bus.ealuimm ? bus.eimm : bus.eb;
    shamt = alua[4:0];
  end

  always_comb begin
    r = '0;
    case (bus.ealuc)
      OP_ADD: r = alua + alub;
      OP_SUB: r = alua - alub;
      OP_AND: r = alua & alub;
      OP_OR:  r = alua | alub;
      OP_XOR: r = alua ^ alub;
      OP_SLL: r = alub << shamt;
      OP_SRL: r = alub >> shamt;
      OP_SRA: r = $unsigned($signed(alub) >>> shamt);
      default: r = '0;
    endcase
  end

`ifdef EXE_OVF_EN
  logic ovf;

  // Sign-bit overflow rule: operands agree (ADD) or disagree (SUB) and the result flips alua's sign.
  always_comb begin
    ovf = 1'b0;
    case (bus.ealuc)
      OP_ADD:  ovf = (alua[WIDTH-1] == alub[WIDTH-1]) && (r[WIDTH-1] != alua[WIDTH-1]);
      OP_SUB:  ovf = (alua[WIDTH-1] != alub[WIDTH-1]) && (r[WIDTH-1] != alua[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ealu <= '0;
      bus.z    <= 1'b1;
      bus.ov   <= 1'b0;
    end else begin
      bus.ealu <= r;
      bus.z    <= (r == '0);
      bus.ov   <= ovf;
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ealu <= '0;
      bus.z    <= 1'b1;
    end else begin
      bus.ealu <= r;
      bus.z    <= (r == '0);
    end
  end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - bench for exe_stage: vector table, directed corners, random vs reference model
module tb_exe_stage;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  exe_stage_if #(.WIDTH(32)) bus ();

  exe_stage #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        imm;
    logic        sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic imm, input logic sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
    bus.ealuc   = op;
    bus.ealuimm = imm;
    bus.eshift  = sh;
    bus.ea      = a;
    bus.eb      = b;
    bus.eimm    = i;
  endtask

  task automatic step(input logic [2:0] op, input logic imm, input logic sh,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
    @(negedge clock);
    drive(op, imm, sh, a, b, i);
    @(posedge clock);
    #1;
  endtask

  // Reference: the ALU written directly from the operation table with plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic imm, input logic sh,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] i);
    logic [31:0] x;
    logic [31:0] y;
    int unsigned s;
    x = sh ? ((i >> 6) & 32'h1F) : a;
    y = imm ? i : b;
    s = x % 32;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return y << s;
      3'd6: return y >> s;
      default: return y[31] ? ~((~y) >> s) : (y >> s);
    endcase
  endfunction

  function automatic logic model_ov(input logic [2:0] op, input logic imm, input logic sh,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] i);
    logic [31:0] x;
    logic [31:0] y;
    longint      res;
    x = sh ? ((i >> 6) & 32'h1F) : a;
    y = imm ? i : b;
    if (op == 3'd0)      res = longint'($signed(x)) + longint'($signed(y));
    else if (op == 3'd1) res = longint'($signed(x)) - longint'($signed(y));
    else                 return 1'b0;
    return (res > 64'sd2147483647) || (res < -64'sd2147483648);
  endfunction

  initial begin
    logic [2:0]  op;
    logic        imm;
    logic        sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [31:0] e;

    total = 0;
    bad   = 0;

    vt[0]  = '{"add",        3'd0, 1'b0, 1'b0, 32'h1,  32'h2,          32'h0,        32'h3};
    vt[1]  = '{"sub",        3'd1, 1'b0, 1'b0, 32'h1,  32'h2,          32'h0,        32'hFFFFFFFF};
    vt[2]  = '{"and",        3'd2, 1'b0, 1'b0, 32'h1,  32'h2,          32'h0,        32'h0};
    vt[3]  = '{"or",         3'd3, 1'b0, 1'b0, 32'h1,  32'h2,          32'h0,        32'h3};
    vt[4]  = '{"xor",        3'd4, 1'b0, 1'b0, 32'h1,  32'h2,          32'h0,        32'h3};
    vt[5]  = '{"sll_sa4",    3'd5, 1'b0, 1'b1, 32'h0,  32'h80000000,   32'h100,      32'h0};
    vt[6]  = '{"srl_sa4",    3'd6, 1'b0, 1'b1, 32'h0,  32'h80000000,   32'h100,      32'h08000000};
    vt[7]  = '{"sra_sa4",    3'd7, 1'b0, 1'b1, 32'h0,  32'h80000000,   32'h100,      32'hF8000000};
    vt[8]  = '{"imm_add",    3'd0, 1'b1, 1'b0, 32'h10, 32'h12345678,   32'hFFFFFFF0, 32'h0};
    vt[9]  = '{"sra_by0",    3'd7, 1'b0, 1'b1, 32'hFF, 32'h80000001,   32'hFFFFF83F, 32'h80000001};
    vt[10] = '{"sll_hi_ign", 3'd5, 1'b0, 1'b0, 32'hFFFFFFE5, 32'h1,    32'h0,        32'h20};

    drive(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset_ealu", bus.ealu, 32'h0);
    chk("reset_z", {31'b0, bus.z}, 32'h1);
`ifdef EXE_OVF_EN
    chk("reset_ov", {31'b0, bus.ov}, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;

    foreach (vt[k]) begin
      step(vt[k].op, vt[k].imm, vt[k].sh, vt[k].a, vt[k].b, vt[k].i);
      chk({vt[k].name, "_alu"}, bus.ealu, vt[k].exp);
      chk({vt[k].name, "_z"}, {31'b0, bus.z}, {31'b0, vt[k].exp == 32'h0});
    end

    // Result must not move until the next rising edge.
    step(3'd0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0);
    @(negedge clock);
    bus.ealuc = 3'd1;
    #2;
    chk("latency_hold", bus.ealu, 32'h3);
    @(posedge clock);
    #1;
    chk("latency_update", bus.ealu, 32'hFFFFFFFF);

    // Mid-cycle reset clears outputs without waiting for a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("midreset_ealu", bus.ealu, 32'h0);
    chk("midreset_z", {31'b0, bus.z}, 32'h1);
    @(posedge clock);
    #1;
    chk("reset_hold_ealu", bus.ealu, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("first_edge_after_reset", bus.ealu, 32'hFFFFFFFF);

`ifdef EXE_OVF_EN
    step(3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0);
    chk("ovf_add_alu", bus.ealu, 32'h80000000);
    chk("ovf_add_ov", {31'b0, bus.ov}, 32'h1);
    step(3'd1, 1'b0, 1'b0, 32'h80000000, 32'h1, 32'h0);
    chk("ovf_sub_ov", {31'b0, bus.ov}, 32'h1);
    step(3'd2, 1'b0, 1'b0, 32'h80000000, 32'h1, 32'h0);
    chk("ovf_and_ov", {31'b0, bus.ov}, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      op  = 3'($urandom_range(0, 7));
      imm = 1'($urandom_range(0, 1));
      sh  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      i   = $urandom;
      if (n % 8 == 0) b = b | 32'h80000000;
      if (n % 16 == 1) a = 32'h7FFFFFFF;
      step(op, imm, sh, a, b, i);
      e = model(op, imm, sh, a, b, i);
      chk($sformatf("rand%0d_op%0d_alu", n, op), bus.ealu, e);
      chk($sformatf("rand%0d_z", n), {31'b0, bus.z}, {31'b0, e == 32'h0});
`ifdef EXE_OVF_EN
      chk($sformatf("rand%0d_ov", n), {31'b0, bus.ov}, {31'b0, model_ov(op, imm, sh, a, b, i)});
`else
      if (model_ov(op, imm, sh, a, b, i) && op > 3'd1) chk("ov_model_sanity", 32'h1, 32'h0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
